// File: rtl/sdram_arbiter.sv
// SDRAM command/address pin owner: hands the pins to init, then arbitrates refresh (top priority)
// and round-robin write/read, with a watchdog that reclaims the pins from a hung sequencer.
module sdram_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        ref_req,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic        flag_ref_end,
  input  logic        flag_wr_end,
  input  logic        flag_rd_end,
  input  logic [3:0]  ref_cmd,
  input  logic [3:0]  wr_cmd,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] ref_addr,
  input  logic [11:0] wr_addr,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  wr_bank,
  input  logic [1:0]  rd_bank,
  output logic        ref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_ba,
  output logic        err_timeout
);

  localparam logic [2:0] StInit  = 3'd0;
  localparam logic [2:0] StArbit = 3'd1;
  localparam logic [2:0] StAref  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StRead  = 3'd4;

  localparam logic [3:0] CmdNop = 4'b0111;

  localparam logic LgWrite = 1'b0;
  localparam logic LgRead  = 1'b1;

  // Release fires on the edge where the counter would reach TIMEOUT, so a grant lasts at most
  // TIMEOUT cycles.
  localparam logic [9:0] WdogLast = 10'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [9:0]  wdog_q, wdog_d;
  logic        err_q, err_d;
  logic        cke_q;
  logic [3:0]  cmd_q, cmd_d;
  logic [11:0] addr_q, addr_d;
  logic [1:0]  ba_q, ba_d;
  logic        granted;
  logic        seq_end;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdog_d  = '0;
    err_d   = 1'b0;
    cmd_d   = CmdNop;
    addr_d  = '0;
    ba_d    = '0;
    granted = 1'b0;
    seq_end = 1'b0;

    case (state_q)
      StInit: begin
        cmd_d  = init_cmd;
        addr_d = init_addr;
        if (init_end) state_d = StArbit;
      end
      StArbit: begin
        if (ref_req) begin
          state_d = StAref;
        end else if (wr_req && rd_req) begin
          if (last_q == LgRead) begin
            state_d = StWrite;
            last_d  = LgWrite;
          end else begin
            state_d = StRead;
            last_d  = LgRead;
          end
        end else if (wr_req) begin
          state_d = StWrite;
          last_d  = LgWrite;
        end else if (rd_req) begin
          state_d = StRead;
          last_d  = LgRead;
        end
      end
      StAref: begin
        granted = 1'b1;
        seq_end = flag_ref_end;
        cmd_d   = ref_cmd;
        addr_d  = ref_addr;
      end
      StWrite: begin
        granted = 1'b1;
        seq_end = flag_wr_end;
        cmd_d   = wr_cmd;
        addr_d  = wr_addr;
        ba_d    = wr_bank;
      end
      StRead: begin
        granted = 1'b1;
        seq_end = flag_rd_end;
        cmd_d   = rd_cmd;
        addr_d  = rd_addr;
        ba_d    = rd_bank;
      end
      default: state_d = StInit;
    endcase

    // An end flag coinciding with the timeout wins, so no error is raised.
    if (granted) begin
      wdog_d = wdog_q + 10'd1;
      if (seq_end) begin
        state_d = StArbit;
      end else if (wdog_q == WdogLast) begin
        state_d = StArbit;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      last_q  <= LgRead;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      cke_q   <= 1'b0;
      cmd_q   <= CmdNop;
      addr_q  <= '0;
      ba_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      cke_q   <= 1'b1;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
    end
  end

  assign ref_en      = (state_q == StAref);
  assign wr_en       = (state_q == StWrite);
  assign rd_en       = (state_q == StRead);
  assign sdram_cke   = cke_q;
  assign sdram_cs_n  = cmd_q[3];
  assign sdram_ras_n = cmd_q[2];
  assign sdram_cas_n = cmd_q[1];
  assign sdram_we_n  = cmd_q[0];
  assign sdram_addr  = addr_q;
  assign sdram_ba    = ba_q;
  assign err_timeout = err_q;

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Owns the SDRAM command/address pins and shares them between the init, auto-refresh, write and read sequencers. After initialisation it grants exactly one sequencer at a time, with refresh at fixed top priority and round-robin fairness between write and read. It drives the selected sequencer's command and address onto the pins through one register stage, and recovers from a hung sequencer with a watchdog.

## Interface
- TIMEOUT, 1023: max cycles a grant may last without an end flag before forced release (10-bit counter).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- init_end  in  1  level; high once the init sequencer has finished power-up.
- init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from init sequencer.
- init_addr  in  12  address from init sequencer.
- ref_req / wr_req / rd_req  in  1 each  level requests from refresh, write and read sequencers.
- flag_ref_end / flag_wr_end / flag_rd_end  in  1 each  single-cycle completion pulses.
- ref_cmd, wr_cmd, rd_cmd  in  4 each  commands.
- ref_addr, wr_addr, rd_addr  in  12 each  addresses.
- wr_bank, rd_bank  in  2 each  bank addresses; refresh and init use bank 2'b00.
- ref_en / wr_en / rd_en  out  1 each  grant levels.
- sdram_cke  out  1  clock enable.
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins.
- sdram_addr  out  12  address pins.
- sdram_ba  out  2  bank pins.
- err_timeout  out  1  single-cycle pulse on a watchdog release.

## Operation
- States:
  - INIT: forwards init_cmd/init_addr; all requests ignored. Leaves to ARBIT when init_end=1.
  - ARBIT: drives NOP, addr 0, ba 0. Evaluates requests in this order:
    - ref_req → AREF.
    - Else if wr_req and rd_req are both high → the sequencer not served last (last_grant).
    - Else whichever single request is high.
    - Else stay in ARBIT.
  - AREF / WRITE / READ: forward that sequencer's cmd/addr/bank. Return to ARBIT on its end flag.
- Grant outputs are pure decodes of the state register: ref_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ). At most one is ever high.
- last_grant:
  - Updates on entry to WRITE (=W) or READ (=R).
  - Reset value R, so write wins the first contended arbitration.
  - Unchanged by AREF.
- End flags not belonging to the current state are ignored.
- A request that drops before being sampled in ARBIT is not granted.
- Arbiter never interrupts a granted sequencer for ref_req. Sequencers see ref_req themselves and end early with their end flag.
- Watchdog:
  - Counter clears in INIT and ARBIT and increments each cycle in AREF/WRITE/READ.
  - When it reaches TIMEOUT without an end flag: next state is ARBIT, err_timeout pulses one cycle, last_grant is unchanged.
  - If the end flag and the timeout occur in the same cycle, the end flag wins and there is no err_timeout.
- Pin encoding: NOP 0111, PRE 0010, AREF 0001, ACT 0011, RD 0101, WR 0100.

## Timing
- Reset values:
  - state INIT, all *_en 0, err_timeout 0.
  - cs_n/ras_n/cas_n/we_n = 0/1/1/1 (NOP).
  - sdram_addr 0, sdram_ba 0, sdram_cke 0.
  - last_grant R, watchdog 0.
- sdram_cke goes to 1 on the first clock after rst deasserts and stays 1.
- Grant latency: request high in ARBIT at cycle N → state/en changes at edge N+1 → en high during cycle N+1.
- End: end flag high at cycle M → en low and state ARBIT from M+1. The earliest next grant is at M+2 (minimum one ARBIT cycle between grants).
- Pins are registered: sequencer cmd/addr at cycle K appear on the pins at K+1. Mux select uses the current state, so a command presented in the same cycle as its end flag is still forwarded.
- Reset asserted mid-grant: on the next edge all outputs take their reset values; no completion of the in-flight sequence.

## Test plan
- Init handover:
  - Stimulus: init_cmd=0010 (PRE) with init_end=0, then raise init_end at cycle 10; hold wr_req high throughout.
  - Required: pins show 0010 one cycle after each input cmd; no wr_en before cycle 11; wr_en rises at cycle 12.
- Priority:
  - Stimulus: in ARBIT, ref_req=wr_req=rd_req=1.
  - Required: ref_en next cycle. After flag_ref_end, one ARBIT cycle, then wr_en. After flag_wr_end, rd_en.
- Round robin:
  - Stimulus: wr_req and rd_req held high, each sequencer ends after 8 cycles.
  - Required: grants alternate W,R,W,R with exactly one NOP cycle between them.
- Command forwarding:
  - Stimulus: during READ, rd_cmd=0011, rd_addr=12'h002, rd_bank=2'b01.
  - Required: pins 0/0/1/1, addr 12'h002, ba 01 one cycle later. In ARBIT, pins are NOP/0/0.
- Watchdog:
  - Stimulus: grant WRITE, never pulse flag_wr_end.
  - Required: after TIMEOUT cycles, err_timeout pulses once and wr_en drops. Repeat with flag_wr_end on the timeout cycle: no err_timeout.
- Reset mid-READ:
  - Stimulus: assert rst for one cycle while rd_en=1.
  - Required: all outputs at reset values the next cycle, state INIT.
